// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register for the RISC-V core. Besides the operands and control, it
// registers precomputed EX operand-mux selects and flags load-use hazards back to ID.
module id_ex_fwd_reg #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_hold,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_alu_src,
    input  logic               id_a_is_pc,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic [4:0]         exmem_rd,
    input  logic               exmem_reg_write,
    output logic               stall_id,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [4:0]         ex_rd,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [1:0]         ex_sel_a,
    output logic [1:0]         ex_sel_b,
    output logic [1:0]         ex_sel_st
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_ALT   = 2'b11;

    logic       ex_prod_ok;
    logic       exmem_prod_ok;
    logic [1:0] fwd_rs1;
    logic [1:0] fwd_rs2;
    logic [1:0] sel_a_nxt;
    logic [1:0] sel_b_nxt;
    logic       load_use;
    logic       bubble;

    // The current EX occupant lands in EX/MEM next cycle; the current EX/MEM lands in MEM/WB.
    assign ex_prod_ok    = ex_valid & ex_reg_write & (ex_rd != 5'd0);
    assign exmem_prod_ok = exmem_reg_write & (exmem_rd != 5'd0);

    always_comb begin
        fwd_rs1 = SEL_RF;
        if (ex_prod_ok && (ex_rd == id_rs1)) begin
            fwd_rs1 = SEL_EXMEM;
        end else if (exmem_prod_ok && (exmem_rd == id_rs1)) begin
            fwd_rs1 = SEL_MEMWB;
        end
    end

    always_comb begin
        fwd_rs2 = SEL_RF;
        if (ex_prod_ok && (ex_rd == id_rs2)) begin
            fwd_rs2 = SEL_EXMEM;
        end else if (exmem_prod_ok && (exmem_rd == id_rs2)) begin
            fwd_rs2 = SEL_MEMWB;
        end
    end

    assign sel_a_nxt = id_a_is_pc ? SEL_ALT : fwd_rs1;
    assign sel_b_nxt = id_alu_src ? SEL_ALT : fwd_rs2;

    // Load data is only available after MEM, so a dependent op must wait one cycle.
    assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign stall_id = load_use & ~flush;
    assign bubble   = flush | stall_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_rd        <= 5'd0;
            ex_sel_a     <= SEL_RF;
            ex_sel_b     <= SEL_RF;
            ex_sel_st    <= SEL_RF;
        end else if (!ex_hold) begin
            if (bubble || !id_valid) begin
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_rd        <= 5'd0;
                ex_sel_a     <= SEL_RF;
                ex_sel_b     <= SEL_RF;
                ex_sel_st    <= SEL_RF;
            end else begin
                ex_valid     <= 1'b1;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
                ex_mem_write <= id_mem_write;
                ex_rd        <= id_rd;
                ex_sel_a     <= sel_a_nxt;
                ex_sel_b     <= sel_b_nxt;
                ex_sel_st    <= fwd_rs2;
            end
        end
    end

    // Data fields are don't-care under a bubble, so they only load on a real capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_alu_op   <= '0;
        end else if (!ex_hold && !bubble) begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_alu_op   <= id_alu_op;
        end
    end

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Directed bench for id_ex_fwd_reg: reset, forwarding selects, load-use stall,
// flush and hold behaviour, each against hand-computed values.
module tb_id_ex_fwd_reg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 4;

    logic               clk;
    logic               rst_n;
    logic               ex_hold;
    logic               flush;
    logic               id_valid;
    logic [XLEN-1:0]    id_pc;
    logic [XLEN-1:0]    id_rs1_data;
    logic [XLEN-1:0]    id_rs2_data;
    logic [XLEN-1:0]    id_imm;
    logic [4:0]         id_rs1;
    logic [4:0]         id_rs2;
    logic [4:0]         id_rd;
    logic               id_reg_write;
    logic               id_mem_read;
    logic               id_mem_write;
    logic               id_alu_src;
    logic               id_a_is_pc;
    logic [ALUOP_W-1:0] id_alu_op;
    logic [4:0]         exmem_rd;
    logic               exmem_reg_write;
    logic               stall_id;
    logic               ex_valid;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic [XLEN-1:0]    ex_pc;
    logic [XLEN-1:0]    ex_rs1_data;
    logic [XLEN-1:0]    ex_rs2_data;
    logic [XLEN-1:0]    ex_imm;
    logic [4:0]         ex_rd;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic [1:0]         ex_sel_a;
    logic [1:0]         ex_sel_b;
    logic [1:0]         ex_sel_st;

    int n_checks;
    int n_errors;

    id_ex_fwd_reg #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_hold         (ex_hold),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_alu_src      (id_alu_src),
        .id_a_is_pc      (id_a_is_pc),
        .id_alu_op       (id_alu_op),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .stall_id        (stall_id),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_pc           (ex_pc),
        .ex_rs1_data     (ex_rs1_data),
        .ex_rs2_data     (ex_rs2_data),
        .ex_imm          (ex_imm),
        .ex_rd           (ex_rd),
        .ex_alu_op       (ex_alu_op),
        .ex_sel_a        (ex_sel_a),
        .ex_sel_b        (ex_sel_b),
        .ex_sel_st       (ex_sel_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                          input logic src, input logic apc);
        id_valid     = 1'b1;
        id_pc        = pc;
        id_rs1_data  = pc + 32'h1000;
        id_rs2_data  = pc + 32'h2000;
        id_imm       = pc + 32'h3000;
        id_alu_op    = pc[5:2];
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
        id_alu_src   = src;
        id_a_is_pc   = apc;
    endtask

    task automatic set_exmem(input logic [4:0] rd, input logic rw);
        exmem_rd        = rd;
        exmem_reg_write = rw;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset with every input driven nonzero
        rst_n    = 1'b0;
        ex_hold  = 1'b1;
        flush    = 1'b1;
        set_id(32'hFFFF_FFF0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        set_exmem(5'd3, 1'b1);
        repeat (3) tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_rd", ex_rd, 0);
        chk("rst_rw", ex_reg_write, 0);
        chk("rst_sel_a", ex_sel_a, 0);
        chk("rst_sel_b", ex_sel_b, 0);
        chk("rst_sel_st", ex_sel_st, 0);
        chk("rst_stall", stall_id, 0);

        // First instruction after release: add x5,x1,x2
        rst_n   = 1'b1;
        ex_hold = 1'b0;
        flush   = 1'b0;
        set_exmem(5'd0, 1'b0);
        set_id(32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("cap_valid", ex_valid, 1);
        chk("cap_pc", ex_pc, 32'h100);
        chk("cap_rs1d", ex_rs1_data, 32'h1100);
        chk("cap_imm", ex_imm, 32'h3100);
        chk("cap_rd", ex_rd, 5);
        chk("cap_rw", ex_reg_write, 1);
        chk("cap_sel_a", ex_sel_a, 0);
        chk("cap_sel_b", ex_sel_b, 0);

        // add x6,x5,x5 behind add x5
        set_id(32'h104, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("exfwd_sel_a", ex_sel_a, 2'b01);
        chk("exfwd_sel_b", ex_sel_b, 2'b01);
        chk("exfwd_sel_st", ex_sel_st, 2'b01);

        // EX writes x7 and EX/MEM writes x7: EX occupant wins
        set_id(32'h108, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_exmem(5'd7, 1'b1);
        set_id(32'h10C, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("prio_sel_a", ex_sel_a, 2'b01);
        chk("prio_sel_b", ex_sel_b, 2'b00);
        // EX occupant now writes x0, so only EX/MEM matches
        set_id(32'h110, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("memwb_sel_a", ex_sel_a, 2'b10);
        chk("memwb_sel_b", ex_sel_b, 2'b00);

        // lw x3 then add x4,x3,x1: load-use stall
        set_exmem(5'd0, 1'b0);
        set_id(32'h120, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("lw_mr", ex_mem_read, 1);
        chk("lw_sel_b", ex_sel_b, 2'b11);
        set_id(32'h124, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_stall", stall_id, 1);
        tick();
        chk("lu_bub_valid", ex_valid, 0);
        chk("lu_bub_rd", ex_rd, 0);
        chk("lu_bub_rw", ex_reg_write, 0);
        chk("lu_bub_mr", ex_mem_read, 0);
        chk("lu_bub_sel_b", ex_sel_b, 0);
        chk("lu_bub_pc_kept", ex_pc, 32'h120);
        chk("lu_stall_clear", stall_id, 0);
        set_exmem(5'd3, 1'b1);
        tick();
        chk("lu_re_valid", ex_valid, 1);
        chk("lu_re_rd", ex_rd, 4);
        chk("lu_re_pc", ex_pc, 32'h124);
        chk("lu_re_sel_a", ex_sel_a, 2'b10);
        chk("lu_re_sel_b", ex_sel_b, 2'b00);

        // add x9 then sw x9,0(x2)
        set_exmem(5'd0, 1'b0);
        set_id(32'h130, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(32'h134, 5'd2, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("sw_sel_a", ex_sel_a, 2'b00);
        chk("sw_sel_b", ex_sel_b, 2'b11);
        chk("sw_sel_st", ex_sel_st, 2'b01);
        chk("sw_mw", ex_mem_write, 1);

        // x0 writers never forward
        set_id(32'h140, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_exmem(5'd0, 1'b1);
        set_id(32'h144, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("x0_sel_a", ex_sel_a, 2'b00);
        chk("x0_sel_b", ex_sel_b, 2'b00);
        chk("x0_sel_st", ex_sel_st, 2'b00);

        // auipc-style: PC and immediate operands, store select still tracks rs2
        set_exmem(5'd0, 1'b0);
        set_id(32'h148, 5'd10, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("pc_sel_a", ex_sel_a, 2'b11);
        chk("pc_sel_b", ex_sel_b, 2'b11);
        chk("pc_sel_st", ex_sel_st, 2'b01);

        // Flush with a load-use pending
        set_id(32'h150, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_id(32'h154, 5'd0, 5'd3, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("fl_pre_stall", stall_id, 1);
        flush = 1'b1;
        #1;
        chk("fl_stall", stall_id, 0);
        tick();
        chk("fl_valid", ex_valid, 0);
        chk("fl_mr", ex_mem_read, 0);
        chk("fl_rd", ex_rd, 0);
        flush = 1'b0;

        // Hold for three cycles with changing inputs; a flush during hold is ignored
        set_id(32'h200, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("hd_cap_pc", ex_pc, 32'h200);
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(32'h300 + 32'(i * 4), 5'd13, 5'd13, 5'(20 + i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            flush = (i == 1);
            tick();
            chk("hd_pc", ex_pc, 32'h200);
            chk("hd_rd", ex_rd, 13);
            chk("hd_valid", ex_valid, 1);
            chk("hd_rw", ex_reg_write, 1);
            chk("hd_mw", ex_mem_write, 0);
            chk("hd_sel_a", ex_sel_a, 0);
        end
        flush = 1'b0;

        // Reset while held clears at once; first valid ID afterwards captures
        rst_n = 1'b0;
        #1;
        chk("ar_valid", ex_valid, 0);
        chk("ar_pc", ex_pc, 0);
        tick();
        rst_n   = 1'b1;
        ex_hold = 1'b0;
        set_id(32'h400, 5'd1, 5'd2, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ar_cap_valid", ex_valid, 1);
        chk("ar_cap_pc", ex_pc, 32'h400);
        chk("ar_cap_rd", ex_rd, 14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
